vga_term_ctl: RTL and testbench

- Terminal sequencer for the 80x25 text VGA adapter.
- Accepts a byte stream over a valid/ready handshake and interprets control codes.
- Acts as Wishbone master on the adapter's VRAM port to write glyphs, scroll and clear the screen.
- Drives the adapter's cursor address, cursor_on, cursor_type and flash inputs.
- Row 0 is the service line: the terminal never writes, scrolls or clears it.

---
 rtl/vga_term_pkg.sv | 38 +++
 rtl/vga_term_flash.sv | 37 +++
 rtl/vga_term_ctl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_vga_term_ctl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_term_pkg.sv
// Shared types and constants for the 80x25 text terminal sequencer.
package vga_term_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_WR_CHAR,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_FILL
    } term_state_e;

    localparam logic [7:0] CC_BS   = 8'h08;
    localparam logic [7:0] CC_LF   = 8'h0A;
    localparam logic [7:0] CC_FF   = 8'h0C;
    localparam logic [7:0] CC_CR   = 8'h0D;
    localparam logic [7:0] CC_CURT = 8'h0E;
    localparam logic [7:0] CC_ESC  = 8'h1B;

    localparam logic [15:0] FILL_WORD = 16'h2020;

    localparam int DEF_COLS    = 80;
    localparam int DEF_ROWS    = 25;
    localparam int DEF_TOP_ROW = 1;

    // A scroll moves every terminal row except the first one up by one row.
    function automatic int scroll_words(input int cols, input int rows, input int top_row);
        return (rows - top_row - 1) * cols / 2;
    endfunction

    function automatic int row_words(input int cols);
        return cols / 2;
    endfunction

    localparam int SCROLL_WORDS = scroll_words(DEF_COLS, DEF_ROWS, DEF_TOP_ROW);
    localparam int ROW_WORDS    = row_words(DEF_COLS);

endpackage

// File: rtl/vga_term_flash.sv
// Free-running blink divider: flash_o toggles every FLASH_DIV clocks.
module vga_term_flash #(
    parameter int FLASH_DIV = 12500000
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    output logic flash_o
);

    localparam int CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flash_q, flash_d;

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        flash_d = flash_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
        end
    end

    assign flash_o = flash_q;

endmodule

// File: rtl/vga_term_ctl.sv
// Terminal sequencer: decodes a byte stream and drives the text adapter's
// VRAM through single classic Wishbone cycles, plus cursor and blink controls.
module vga_term_ctl
    import vga_term_pkg::*;
#(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25,
    parameter int          TOP_ROW   = 1,
    parameter logic [15:0] VRAM_BASE = 16'h0000,
    parameter int          FLASH_DIV = 12500000,
    parameter bit          CUR_BLOCK = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  ch_i,
    input  logic        ch_valid_i,
    output logic        ch_ready_o,
    output logic [15:0] m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    input  logic        m_ack_i,
    output logic [10:0] cursor_o,
    output logic        cursor_on_o,
    output logic        cursor_type_o,
    output logic        flash_o,
    output logic        busy_o
);

    localparam int          SCR_WORDS  = scroll_words(COLS, ROWS, TOP_ROW);
    localparam int          TAIL_WORDS = row_words(COLS);
    localparam int          FF_WORDS   = (ROWS - TOP_ROW) * COLS / 2;
    localparam logic [10:0] SCR_SRC0   = 11'((TOP_ROW + 1) * COLS);
    localparam logic [10:0] FF_START   = 11'(TOP_ROW * COLS);
    localparam logic [10:0] TAIL_START = 11'((ROWS - 1) * COLS);
    localparam logic [10:0] COLS_W     = 11'(COLS);
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
    localparam logic [4:0]  FIRST_ROW  = 5'(TOP_ROW);

    term_state_e state_q, state_d;
    logic [7:0]  ch_q, ch_d;
    logic        pend_q, pend_d;
    logic        rdy_q, rdy_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [10:0] ptr_q, ptr_d;
    logic [9:0]  wcnt_q, wcnt_d;
    logic [9:0]  nwords_q, nwords_d;
    logic        home_q, home_d;
    logic [15:0] rdat_q, rdat_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        ctype_q, ctype_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic [10:0] cursor_w;
    logic [15:0] char_adr;

    assign accept   = ch_valid_i & rdy_q;
    assign cursor_w = 11'(row_q) * COLS_W + 11'(col_q);
    assign char_adr = VRAM_BASE + 16'(cursor_w);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        pend_d   = pend_q;
        row_d    = row_q;
        col_d    = col_q;
        ptr_d    = ptr_q;
        wcnt_d   = wcnt_q;
        nwords_d = nwords_q;
        home_d   = home_q;
        rdat_d   = rdat_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        ctype_d  = ctype_q;

        if (accept) begin
            ch_d   = ch_i;
            pend_d = 1'b1;
        end

        // Bus states raise the strobe from an idle bus and drop it in the ack
        // cycle, which guarantees a low cycle between consecutive transfers.
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    case (ch_q)
                        CC_CR: col_d = '0;
                        CC_BS: begin
                            if (col_q != '0) col_d = col_q - 7'd1;
                        end
                        CC_LF: begin
                            if (row_q != LAST_ROW) begin
                                row_d = row_q + 5'd1;
                            end else begin
                                state_d = ST_SCR_RD;
                                ptr_d   = SCR_SRC0;
                                wcnt_d  = '0;
                            end
                        end
                        CC_FF: begin
                            state_d  = ST_FILL;
                            ptr_d    = FF_START;
                            wcnt_d   = '0;
                            nwords_d = 10'(FF_WORDS);
                            home_d   = 1'b1;
                        end
                        CC_ESC:  state_d = ST_ESC;
                        CC_CURT: ctype_d = ~ctype_q;
                        default: state_d = ST_WR_CHAR;
                    endcase
                end
            end
            ST_ESC: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_WR_CHAR;
                end
            end
            ST_WR_CHAR: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = char_adr;
                    sel_d = char_adr[0] ? 2'b10 : 2'b01;
                    dat_d = {ch_q, ch_q};
                end else if (m_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q != LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            state_d = ST_SCR_RD;
                            ptr_d   = SCR_SRC0;
                            wcnt_d  = '0;
                        end
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            ST_SCR_RD: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    sel_d = 2'b11;
                    adr_d = VRAM_BASE + 16'(ptr_q);
                end else if (m_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    rdat_d  = m_dat_i;
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 2'b11;
                    adr_d = VRAM_BASE + 16'(ptr_q - COLS_W);
                    dat_d = rdat_q;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (wcnt_q == 10'(SCR_WORDS - 1)) begin
                        state_d  = ST_FILL;
                        ptr_d    = TAIL_START;
                        wcnt_d   = '0;
                        nwords_d = 10'(TAIL_WORDS);
                        home_d   = 1'b0;
                    end else begin
                        state_d = ST_SCR_RD;
                        ptr_d   = ptr_q + 11'd2;
                        wcnt_d  = wcnt_q + 10'd1;
                    end
                end
            end
            ST_FILL: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 2'b11;
                    adr_d = VRAM_BASE + 16'(ptr_q);
                    dat_d = FILL_WORD;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (wcnt_q == nwords_q - 10'd1) begin
                        state_d = ST_IDLE;
                        if (home_q) begin
                            row_d = FIRST_ROW;
                            col_d = '0;
                        end
                    end else begin
                        ptr_d  = ptr_q + 11'd2;
                        wcnt_d = wcnt_q + 10'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready is withheld for the decode cycle so one byte is handled at a time.
        rdy_d  = !accept && !pend_d && ((state_d == ST_IDLE) || (state_d == ST_ESC));
        busy_d = (state_d == ST_SCR_RD) || (state_d == ST_SCR_WR) || (state_d == ST_FILL);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            pend_q   <= 1'b0;
            rdy_q    <= 1'b0;
            row_q    <= FIRST_ROW;
            col_q    <= '0;
            ptr_q    <= '0;
            wcnt_q   <= '0;
            nwords_q <= '0;
            home_q   <= 1'b0;
            rdat_q   <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            ctype_q  <= CUR_BLOCK;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            pend_q   <= pend_d;
            rdy_q    <= rdy_d;
            row_q    <= row_d;
            col_q    <= col_d;
            ptr_q    <= ptr_d;
            wcnt_q   <= wcnt_d;
            nwords_q <= nwords_d;
            home_q   <= home_d;
            rdat_q   <= rdat_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            ctype_q  <= ctype_d;
            busy_q   <= busy_d;
        end
    end

    vga_term_flash #(
        .FLASH_DIV (FLASH_DIV)
    ) u_flash (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .flash_o  (flash_o)
    );

    assign ch_ready_o    = rdy_q;
    assign m_adr_o       = adr_q;
    assign m_dat_o       = dat_q;
    assign m_cyc_o       = cyc_q;
    assign m_stb_o       = stb_q;
    assign m_we_o        = we_q;
    assign m_sel_o       = sel_q;
    assign cursor_o      = cursor_w;
    assign cursor_on_o   = ~busy_q;
    assign cursor_type_o = ctype_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_vga_term_ctl.sv
// Bench for vga_term_ctl: VRAM slave model, transaction scoreboard, terminal model.
module tb_vga_term_ctl;

    localparam int W = 35;  // {we, sel[1:0], adr[15:0], dat[15:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ch_i = 8'h00;
    logic        ch_valid = 1'b0;
    logic        ch_ready_o;
    logic [15:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [1:0]  m_sel_o;
    logic        m_ack = 1'b0;
    logic [10:0] cursor_o;
    logic        cursor_on_o, cursor_type_o, flash_o, busy_o;

    vga_term_ctl #(.FLASH_DIV(4)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .ch_i          (ch_i),
        .ch_valid_i    (ch_valid),
        .ch_ready_o    (ch_ready_o),
        .m_adr_o       (m_adr_o),
        .m_dat_o       (m_dat_o),
        .m_dat_i       (m_dat_i),
        .m_cyc_o       (m_cyc_o),
        .m_stb_o       (m_stb_o),
        .m_we_o        (m_we_o),
        .m_sel_o       (m_sel_o),
        .m_ack_i       (m_ack),
        .cursor_o      (cursor_o),
        .cursor_on_o   (cursor_on_o),
        .cursor_type_o (cursor_type_o),
        .flash_o       (flash_o),
        .busy_o        (busy_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // VRAM slave: ack one cycle after strobe, writes land on the ack edge
    logic [7:0] mem [0:2047];
    logic [7:0] shadow [0:2047];

    always @(posedge clk or posedge rst) begin
        if (rst) m_ack <= 1'b0;
        else     m_ack <= m_cyc_o && m_stb_o && !m_ack;
    end

    always @(posedge clk) begin
        if (!rst && m_cyc_o && m_stb_o && m_we_o && m_ack) begin
            if (m_sel_o[0]) mem[{m_adr_o[10:1], 1'b0}] <= m_dat_o[7:0];
            if (m_sel_o[1]) mem[{m_adr_o[10:1], 1'b1}] <= m_dat_o[15:8];
        end
    end

    assign m_dat_i = {mem[{m_adr_o[10:1], 1'b1}], mem[{m_adr_o[10:1], 1'b0}]};

    // scoreboard
    logic [W-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  bus_cnt = 0, busy_bad = 0, proto_bad = 0;
    int  flash_bad = 0, flash_toggles = 0;
    bit  mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // monitor: one comparison per acknowledged transfer
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        logic [W-1:0] e, got;
        if (rst) begin
            prev_ack = 1'b0;
        end else begin
            if (m_stb_o && prev_ack) proto_bad++;
            if (m_stb_o && !m_cyc_o) proto_bad++;
            if (m_cyc_o && m_stb_o && m_ack) begin
                bus_cnt++;
                if (m_sel_o == 2'b11 && !(busy_o && !cursor_on_o && !ch_ready_o)) busy_bad++;
                if (mon_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_unexpected: got we=%0b sel=%b adr=%0d dat=%h, required no transfer",
                                 m_we_o, m_sel_o, m_adr_o, m_dat_o);
                    end else begin
                        e   = exp_q.pop_front();
                        got = {m_we_o, m_sel_o, m_adr_o, (e[34] ? m_dat_o : 16'h0000)};
                        if (got !== e) begin
                            errors++;
                            $display("FAIL bus_xfer: got we=%0b sel=%b adr=%0d dat=%h, required we=%0b sel=%b adr=%0d dat=%h",
                                     got[34], got[33:32], got[31:16], got[15:0], e[34], e[33:32], e[31:16], e[15:0]);
                        end
                    end
                end
            end
            prev_ack = m_cyc_o && m_stb_o && m_ack;
        end
    end

    // flash half-period monitor
    logic fl_prev = 1'b0;
    bit   fl_have = 1'b0;
    int   fl_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            fl_prev = 1'b0;
            fl_have = 1'b0;
            fl_cnt  = 0;
        end else begin
            fl_cnt++;
            if (flash_o !== fl_prev) begin
                if (fl_have && fl_cnt != 4) flash_bad++;
                fl_have = 1'b1;
                fl_cnt  = 0;
                fl_prev = flash_o;
                flash_toggles++;
            end
        end
    end

    // terminal model
    int   mrow = 1, mcol = 0;
    logic mtype = 1'b0;
    bit   mesc = 1'b0;

    task automatic push_wr(input int adr, input logic [1:0] sel, input logic [15:0] dat);
        exp_q.push_back({1'b1, sel, 16'(adr), dat});
        if (sel[0]) shadow[(adr & ~1)]     = dat[7:0];
        if (sel[1]) shadow[(adr & ~1) + 1] = dat[15:8];
    endtask

    task automatic push_rd(input int adr);
        exp_q.push_back({1'b0, 2'b11, 16'(adr), 16'h0000});
    endtask

    task automatic push_scroll();
        for (int w = 0; w < 920; w++) begin
            push_rd(160 + 2 * w);
            push_wr(80 + 2 * w, 2'b11, {shadow[161 + 2 * w], shadow[160 + 2 * w]});
        end
        for (int k = 0; k < 40; k++) push_wr(1920 + 2 * k, 2'b11, 16'h2020);
    endtask

    task automatic model_char(input logic [7:0] c);
        int a;
        a = mrow * 80 + mcol;
        push_wr(a, a[0] ? 2'b10 : 2'b01, {c, c});
        if (mcol == 79) begin
            mcol = 0;
            if (mrow < 24) mrow++;
            else push_scroll();
        end else begin
            mcol++;
        end
    endtask

    // driver
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        ch_i     = b;
        ch_valid = 1'b1;
        while (!ch_ready_o && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(ch_ready_o), 32'd1);
        @(posedge clk);
        #1 ch_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ch_ready_o && n < budget);
        check({tag, " ready_timeout"}, 32'(ch_ready_o), 32'd1);
    endtask

    task automatic term_byte(input logic [7:0] b, input string tag);
        if (mesc) begin
            model_char(b);
            mesc = 1'b0;
        end else begin
            case (b)
                8'h0D: mcol = 0;
                8'h08: if (mcol > 0) mcol--;
                8'h0A: if (mrow < 24) mrow++; else push_scroll();
                8'h0C: begin
                    for (int k = 0; k < 960; k++) push_wr(80 + 2 * k, 2'b11, 16'h2020);
                    mrow = 1;
                    mcol = 0;
                end
                8'h1B: mesc = 1'b1;
                8'h0E: mtype = ~mtype;
                default: model_char(b);
            endcase
        end
        send(b);
        wait_ready(tag, 12000);
        check({tag, " cursor"}, 32'(cursor_o), 32'(mrow * 80 + mcol));
        check({tag, " cursor_type"}, 32'(cursor_type_o), 32'(mtype));
        check({tag, " drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, " busy_after"}, 32'(busy_o), 32'd0);
        check({tag, " cursor_on_after"}, 32'(cursor_on_o), 32'd1);
    endtask

    // stimulus
    initial begin
        int n, bad0, bad1;
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end

        repeat (3) @(negedge clk);
        check("rst cursor", 32'(cursor_o), 32'd80);
        check("rst cursor_on", 32'(cursor_on_o), 32'd1);
        check("rst cursor_type", 32'(cursor_type_o), 32'd0);
        check("rst flash", 32'(flash_o), 32'd0);
        check("rst cyc", 32'(m_cyc_o), 32'd0);
        check("rst stb", 32'(m_stb_o), 32'd0);
        check("rst we", 32'(m_we_o), 32'd0);
        check("rst sel", 32'(m_sel_o), 32'd0);
        check("rst adr", 32'(m_adr_o), 32'd0);
        check("rst dat", 32'(m_dat_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst ready", 32'(ch_ready_o), 32'd0);
        rst = 1'b0;

        // glyphs at even then odd address
        term_byte(8'h41, "char_A");
        term_byte(8'h42, "char_B");
        // escaped control code is a glyph; bare BS / CR / BS-at-col0
        term_byte(8'h1B, "esc");
        term_byte(8'h08, "esc_bs_glyph");
        term_byte(8'h08, "bs");
        term_byte(8'h0D, "cr");
        term_byte(8'h08, "bs_col0");
        term_byte(8'h0E, "curt");

        // walk to row 24, fill the row to col 79, then wrap into a scroll
        for (int i = 0; i < 23; i++) term_byte(8'h0A, "lf_down");
        for (int i = 0; i < 79; i++) term_byte(8'(8'h61 + (i % 26)), "row24_char");
        term_byte(8'h78, "wrap_scroll");
        check("scroll busy_window", 32'(busy_bad), 32'd0);
        check("scroll protocol", 32'(proto_bad), 32'd0);

        // reset in the middle of a scroll
        mon_en = 1'b0;
        send(8'h0A);
        repeat (40) @(negedge clk);
        n = 0;
        while (!m_cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst cyc_before", 32'(m_cyc_o), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst cyc", 32'(m_cyc_o), 32'd0);
        check("midrst stb", 32'(m_stb_o), 32'd0);
        check("midrst cursor", 32'(cursor_o), 32'd80);
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst cursor_type", 32'(cursor_type_o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        mrow   = 1;
        mcol   = 0;
        mtype  = 1'b0;
        mesc   = 1'b0;
        wait_ready("midrst", 10);
        check("midrst cursor_after", 32'(cursor_o), 32'd80);
        check("midrst cursor_on_after", 32'(cursor_on_o), 32'd1);

        // position to 1234 then clear the screen
        for (int i = 0; i < 14; i++) term_byte(8'h0A, "lf_pos");
        for (int i = 0; i < 34; i++) term_byte(8'(8'h61 + (i % 26)), "pos_char");
        check("pos cursor_1234", 32'(cursor_o), 32'd1234);
        term_byte(8'h0C, "form_feed");
        check("ff busy_ready_window", 32'(busy_bad), 32'd0);
        check("ff protocol", 32'(proto_bad), 32'd0);

        bad0 = 0;
        bad1 = 0;
        for (int i = 0; i < 80; i++) if (mem[i] !== 8'(i * 7 + 3)) bad0++;
        for (int i = 80; i < 2000; i++) if (mem[i] !== 8'h20) bad1++;
        check("vram service_row_untouched", 32'(bad0), 32'd0);
        check("vram cleared", 32'(bad1), 32'd0);

        check("flash half_period", 32'(flash_bad), 32'd0);
        check("flash toggling", 32'(flash_toggles > 1000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
